// File: rtl/lamp_controller_pwm.sv
// Vehicle lamp controller: PWM tail/brake/reverse lamps, auto-light with
// hysteresis and dwell, turn/hazard blinker and flash-to-pass headlamps.
module lamp_controller_pwm #(
  parameter int PWM_W      = 4,
  parameter int TAIL_DUTY  = 5,
  parameter int REV_DUTY   = 11,
  parameter int BRAKE_DUTY = 16,
  parameter int CDS_W      = 8,
  parameter int DARK_ON    = 200,
  parameter int DARK_OFF   = 220,
  parameter int DWELL      = 4,
  parameter int BLINK_HALF = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_headlight,
  input  logic             sw_high_beam,
  input  logic             pass_req,
  input  logic [CDS_W-1:0] cds_val,
  input  logic             is_brake,
  input  logic             is_reverse,
  input  logic             turn_left_req,
  input  logic             turn_right_req,
  input  logic             hazard_req,
  output logic [3:0]       fc_red,
  output logic [3:0]       fc_green,
  output logic [3:0]       fc_blue,
  output logic [7:0]       led_port,
  output logic             is_dark,
  output logic             blink_on
);

  localparam int PW1  = PWM_W + 1;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TM_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PW1-1:0]   TAIL_D     = PW1'(TAIL_DUTY);
  localparam logic [PW1-1:0]   REV_D      = PW1'(REV_DUTY);
  localparam logic [PW1-1:0]   BRAKE_D    = PW1'(BRAKE_DUTY);
  localparam logic [CDS_W-1:0] DARK_ON_V  = CDS_W'(DARK_ON);
  localparam logic [CDS_W-1:0] DARK_OFF_V = CDS_W'(DARK_OFF);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [TM_W-1:0]  HALF_LAST  = TM_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} blink_t;

  // One extra bit lets a duty of 2^PWM_W mean "always on".
  function automatic logic pwm(input logic [PWM_W-1:0] c, input logic [PW1-1:0] d);
    return {1'b0, c} < d;
  endfunction

  logic [PWM_W-1:0] cnt;
  logic [DW_W-1:0]  dwell_cnt;
  logic [TM_W-1:0]  timer;
  blink_t           state;
  logic             toggle_dark, head_on, high_on, any_req, left_side, right_side;
  logic             tail_outer, tail_inner;
  logic             tail_outer_p1, tail_inner_p1, turn_l_p1, turn_r_p1;

  assign toggle_dark = (!is_dark && (cds_val < DARK_ON_V)) || (is_dark && (cds_val > DARK_OFF_V));
  assign head_on     = sw_headlight | is_dark;
  assign high_on     = (head_on & sw_high_beam) | pass_req;
  assign tail_outer  = is_brake ? pwm(cnt, BRAKE_D) : (head_on & pwm(cnt, TAIL_D));
  assign tail_inner  = is_reverse ? pwm(cnt, REV_D) : tail_outer;
  assign any_req     = turn_left_req | turn_right_req | hazard_req;
  assign left_side   = hazard_req | turn_left_req;
  assign right_side  = hazard_req | turn_right_req;

  // Stage p1: registered headlamps, tails and auto-light filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      dwell_cnt     <= '0;
      is_dark       <= 1'b0;
      fc_red        <= '0;
      fc_green      <= '0;
      fc_blue       <= '0;
      tail_outer_p1 <= 1'b0;
      tail_inner_p1 <= 1'b0;
    end else begin
      cnt           <= cnt + 1'b1;
      fc_red        <= {head_on, head_on, high_on, high_on};
      fc_green      <= {head_on, head_on, high_on, high_on};
      fc_blue       <= {head_on, head_on, high_on, high_on};
      tail_outer_p1 <= tail_outer;
      tail_inner_p1 <= tail_inner;
      if (!toggle_dark) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt == DWELL_LAST) begin
        is_dark   <= ~is_dark;
        dwell_cnt <= '0;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  // Stage p1: blinker FSM; lamp bits follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      blink_on  <= 1'b0;
      turn_l_p1 <= 1'b0;
      turn_r_p1 <= 1'b0;
    end else if (!any_req) begin
      state     <= IDLE;
      timer     <= '0;
      blink_on  <= 1'b0;
      turn_l_p1 <= 1'b0;
      turn_r_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= ON;
          timer     <= '0;
          blink_on  <= 1'b1;
          turn_l_p1 <= left_side;
          turn_r_p1 <= right_side;
        end
        ON: begin
          if (timer == HALF_LAST) begin
            state     <= OFF;
            timer     <= '0;
            blink_on  <= 1'b0;
            turn_l_p1 <= 1'b0;
            turn_r_p1 <= 1'b0;
          end else begin
            timer     <= timer + 1'b1;
            blink_on  <= 1'b1;
            turn_l_p1 <= left_side;
            turn_r_p1 <= right_side;
          end
        end
        OFF: begin
          if (timer == HALF_LAST) begin
            state     <= ON;
            timer     <= '0;
            blink_on  <= 1'b1;
            turn_l_p1 <= left_side;
            turn_r_p1 <= right_side;
          end else begin
            timer     <= timer + 1'b1;
            blink_on  <= 1'b0;
            turn_l_p1 <= 1'b0;
            turn_r_p1 <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          blink_on  <= 1'b0;
          turn_l_p1 <= 1'b0;
          turn_r_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign led_port = {turn_l_p1, turn_l_p1, tail_outer_p1, tail_inner_p1,
                     tail_inner_p1, tail_outer_p1, turn_r_p1, turn_r_p1};

endmodule
